// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches instr_in and PC+4 into IF/ID one edge after the PC is presented.
// Redirects (jump > branch) flush with one bubble and override stall; HALT and FAULT are terminal until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] redirect_base,
    input  logic        halt,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        fault,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        if_valid_q, if_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        pc_illegal;

    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {redirect_base[31:28], jump_index, 2'b00};
    assign branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign branch_target = redirect_base + branch_offset;
    // Zero-extend so a limit of 2^32 bytes still compares correctly.
    assign pc_illegal    = ({1'b0, pc_q} >= PC_LIMIT) || (pc_q[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        fault_d       = fault_q;
        instr_count_d = instr_count_q;

        case (state_q)
            S_BOOT: begin
                if_valid_d = 1'b0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (pc_illegal) begin
                    fault_d    = 1'b1;
                    if_valid_d = 1'b0;
                    state_d    = S_FAULT;
                end else if (halt) begin
                    if_valid_d = 1'b0;
                    state_d    = S_HALT;
                end else if (jump) begin
                    pc_d       = jump_target;
                    if_valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d       = branch_target;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_instr_d    = instr_in;
                    if_pc_plus4_d = pc_plus4;
                    if_valid_d    = 1'b1;
                    instr_count_d = instr_count_q + 32'd1;
                    pc_d          = pc_plus4;
                end
            end
            S_HALT, S_FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = S_BOOT;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            if_instr_q    <= 32'd0;
            if_pc_plus4_q <= 32'd0;
            if_valid_q    <= 1'b0;
            fault_q       <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;
    assign fault       = fault_q;
    assign instr_count = instr_count_q;

endmodule
